nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

- Multi-cycle adder for WIDTH-bit operands, built from a single 4-bit carry-lookahead slice.
- Processes one nibble per clock, least-significant first, and holds the carry in a register between nibbles.
- Sits directly upstream of result consumers that need a WIDTH-bit sum, and reuses the team's verified 4-bit CLA behaviour instead of building a wide combinational adder.
- Uses valid/ready handshakes on both input and output.

## Interface
- WIDTH, default 16, operand width in bits; must be a multiple of 4 and at least 8.
- Ports:
  - clk  in  1  single clock; all state changes on its rising edge.
  - rst  in  1  synchronous, active-high reset.
  - in_valid  in  1  operand set offered.
  - in_ready  out  1  block can accept operands.
  - a  in  WIDTH  operand A, unsigned.
  - b  in  WIDTH  operand B, unsigned.
  - cin  in  1  carry into nibble 0.
  - out_valid  out  1  result available.
  - out_ready  in  1  consumer takes the result.
  - sum  out  WIDTH  registered sum, modulo 2^WIDTH.
  - cout  out  1  carry out of the top nibble.
  - ovf  out  1  signed overflow; present only with NSA_OVERFLOW_EN.

## Operation
- Fixed: one clock `clk`; reset `rst`, synchronous and active-high.
- N = WIDTH/4.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch a, b into operand registers; carry_q <= cin; idx <= 0; go to RUN.
- RUN:
  - The CLA slice adds nibble idx of A, nibble idx of B and carry_q.
  - Each cycle: write the 4-bit result into sum[4*idx +: 4]; carry_q <= slice cout; idx <= idx + 1.
  - When idx == N-1, write cout <= slice cout and go to DONE.
- DONE:
  - out_valid = 1.
  - sum, cout and ovf held stable until out_valid & out_ready, then return to IDLE.
- in_ready = 0 in RUN and DONE. Operands offered then are not accepted, and a and b may change freely.
- An input is never accepted in the same cycle as an output handshake.
- sum bits of nibbles not yet written in RUN are don't-care. sum is only defined while out_valid = 1.
- Arithmetic:
  - {cout, sum} == a + b + cin, exactly, for all inputs.
  - The idx counter is ceil(log2(N)) bits wide and never wraps inside one operation.

## Timing
- Reset values: in_ready 0 while rst is high, 1 in the cycle after rst deasserts; out_valid 0; sum 0; cout 0; ovf 0; state IDLE; carry_q 0; idx 0.
- Latency:
  - Accept handshake on edge T.
  - RUN occupies edges T+1 .. T+N.
  - out_valid is high from the cycle following edge T+N.
  - Result is visible N cycles after acceptance.
- Throughput: one operation per N+2 cycles when out_ready is tied high.
- Backpressure: out_ready low keeps DONE indefinitely, with outputs bit-stable.
- Reset mid-RUN or mid-DONE aborts the operation. The partial result is discarded and all outputs return to their reset values on the next edge.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid. Both are decoded from state only.
- In DONE, in_valid with out_ready in the same cycle: only the output handshake completes.

## Configuration
- NSA_OVERFLOW_EN defined:
  - Adds output `ovf`.
  - In the final RUN cycle, ovf <= a[WIDTH-1] ~^ b[WIDTH-1] & (a[WIDTH-1] ^ sum_msb), treating operands as two's complement.
  - ovf is registered alongside cout and cleared by reset.
- NSA_OVERFLOW_EN undefined: no `ovf` port and no related logic. All other behaviour is identical.

## Structure
- Package `cla_pkg`:
  - NIBBLE_W = 4.
  - State enum nsa_state_t (IDLE, RUN, DONE).
  - Helper function for nibble count from WIDTH.
- Sub-module `cla4_core`: purely combinational 4-bit carry-lookahead slice with ports a[3:0], b[3:0], cin, sum[3:0], cout. It is built from generate/propagate terms and has no ripple chain.
- One instance of `cla4_core`, driven by muxes selected by idx.

## Test plan
- WIDTH=16, a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid exactly 4 cycles after accept.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1; carry propagates through all 4 nibbles.
- a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1. Then out_ready held low for 3 cycles -> sum, cout and out_valid stable, in_ready=0; after release, IDLE next cycle.
- Accept a=0x0F0F, b=0x0101; assert rst during the 2nd RUN cycle -> next cycle out_valid=0, sum=0, in_ready=1 after rst drops. A fresh a=0x0001, b=0x0002 then gives 0x0003.
- Back-to-back random operands (1000 ops, WIDTH=16 and WIDTH=32), with in_valid and out_ready toggled randomly -> every result matches a+b+cin, and no operand is lost or duplicated.
- With NSA_OVERFLOW_EN: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, ovf=1, cout=0; a=0x8000, b=0xFFFF -> sum=0x7FFF, ovf=1, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// cla_pkg: shared types and constants for the nibble-serial adder.
//   NIBBLE_W      width of the single carry-lookahead slice
//   nsa_state_t   control FSM states (IDLE, RUN, DONE)
//   nibble_count  number of slice passes for a WIDTH-bit operand
package cla_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_t;

  // WIDTH is required to be a multiple of NIBBLE_W and at least 8.
  function automatic int nibble_count(input int width);
    return width / NIBBLE_W;
  endfunction

endpackage

// File: rtl/cla4_core.sv
// cla4_core: purely combinational 4-bit carry-lookahead adder slice.
// Ports:
//   a, b  [3:0]  addends
//   cin          carry in
//   sum   [3:0]  a + b + cin, low 4 bits
//   cout         carry out of bit 3
// Every carry is a flat sum-of-products of generate/propagate terms and
// cin, so no carry depends on another computed carry.
module cla4_core
  import cla_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  logic [NIBBLE_W-1:0] g, p;
  logic [NIBBLE_W:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that reuses one 4-bit CLA slice,
// one nibble per clock, LSB nibble first, carry held in a register.
// Optional feature macro: NSA_OVERFLOW_EN adds the signed-overflow output.
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset
//   in_valid   operand set offered
//   in_ready   block can accept operands (IDLE only, registered)
//   a, b       WIDTH-bit unsigned operands
//   cin        carry into nibble 0
//   out_valid  result available (DONE only, registered)
//   out_ready  consumer takes the result
//   sum        registered sum modulo 2^WIDTH
//   cout       carry out of the top nibble
//   ovf        two's-complement overflow (NSA_OVERFLOW_EN only)
// Latency: accept on edge T, out_valid high after edge T+N (N = WIDTH/4).
module nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = nibble_count(WIDTH);
  localparam int IDX_W = $clog2(N);

  nsa_state_t state;

  // Operands and result kept as nibble arrays so idx selects a lane directly.
  logic [N-1:0][NIBBLE_W-1:0] a_q, b_q, sum_q;
  logic                       carry_q;
  logic [IDX_W-1:0]           idx;

  logic [NIBBLE_W-1:0] nib_a, nib_b, nib_sum;
  logic                nib_cout;
  logic                last;

  assign nib_a = a_q[idx];
  assign nib_b = b_q[idx];
  assign last  = (idx == IDX_W'(N - 1));

  cla4_core u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  assign sum = sum_q;

  // in_ready and out_valid are registers that track the state, so neither
  // has a combinational path from in_valid / out_ready. in_ready stays low
  // for the first cycle after reset and rises on the following edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      idx       <= '0;
      cout      <= 1'b0;
`ifdef NSA_OVERFLOW_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            carry_q  <= cin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= nib_sum;
          carry_q    <= nib_cout;
          if (last) begin
            // idx is left at N-1 so it never wraps within an operation.
            cout      <= nib_cout;
`ifdef NSA_OVERFLOW_EN
            // Same-sign operands whose result sign differs from them.
            ovf       <= (a_q[N-1][NIBBLE_W-1] ~^ b_q[N-1][NIBBLE_W-1])
                       & (a_q[N-1][NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // in_ready is low here, so an input offered alongside the output
          // handshake is never taken in the same cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16). Accepted operand sets
// push a reference result; a negedge monitor pops on every output handshake.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef NSA_OVERFLOW_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: unsigned sum with wide arithmetic, overflow from signed range.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t           e;
    longint unsigned t;
    longint         sx, sy, r, hi, lo;
    t      = longint'(x) + longint'(y) + longint'(c);
    e.sum  = t[W-1:0];
    e.cout = t[W];
    sx     = $signed(x);
    sy     = $signed(y);
    r      = sx + sy + longint'(c);
    hi     = (longint'(1) << (W - 1)) - 1;
    lo     = -(longint'(1) << (W - 1));
    e.ovf  = (r > hi) || (r < lo);
    return e;
  endfunction

  // Output monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("sum", sum, e.sum);
        check("cout", cout, e.cout);
`ifdef NSA_OVERFLOW_EN
        check("ovf", ovf, e.ovf);
`endif
      end
    end
  end

  // Offer one operand set and hold it until accepted; returns just after
  // the accept edge with in_valid dropped.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb; cin = tc;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(ta, tb, tc));
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    bit ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) check("out_valid_timeout", 0, 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    bit           pending;
    int           issued;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef NSA_OVERFLOW_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // 0x1234 + 0x4321 with exact latency
    send(16'h1234, 16'h4321, 1'b0);
    repeat (N - 1) @(posedge clk);
    @(negedge clk);
    check("latency_early", out_valid, 0);
    @(posedge clk); @(negedge clk);
    check("latency_on", out_valid, 1);
    check("sum_5555", sum, 16'h5555);

    // Carry through every nibble
    send(16'hFFFF, 16'h0001, 1'b0);
    wait_out();
    check("sum_wrap", sum, 16'h0000);
    check("cout_wrap", cout, 1);

    // Backpressure: hold DONE for 3 cycles, offering input meanwhile
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(16'hFFFF, 16'hFFFF, 1'b1);
    wait_out();
    @(posedge clk); #1;
    in_valid = 1'b1; a = 16'hAAAA; b = 16'h5555; cin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum, 16'hFFFF);
      check("bp_cout", cout, 1);
      check("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    check("no_accept_in_done", out_valid, 0);

    // Reset during the 2nd RUN cycle
    send(16'h0F0F, 16'h0101, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_sum", sum, 0);
    check("abort_in_ready", in_ready, 0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort_in_ready_after", in_ready, 1);
    send(16'h0001, 16'h0002, 1'b0);
    wait_out();
    check("fresh_sum", sum, 16'h0003);

`ifdef NSA_OVERFLOW_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    wait_out();
    check("ovf_pos", ovf, 1);
    send(16'h8000, 16'hFFFF, 1'b0);
    wait_out();
    check("ovf_neg", ovf, 1);
    check("ovf_neg_sum", sum, 16'h7FFF);
`endif

    // Random traffic with random valid/ready
    issued = 0; pending = 0;
    for (int cyc = 0; cyc < 60000 && issued < 1000; cyc++) begin
      @(posedge clk); #1;
      if (!pending) begin
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        if ($urandom_range(0, 7) == 0) ra = '1;
        pending = ($urandom_range(0, 3) != 0);
      end
      in_valid  = pending;
      a = ra; b = rb; cin = rc;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ra, rb, rc));
        issued++;
        pending = 0;
      end
    end
    check("random_issued", issued, 1000);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
